// File: rtl/lut_coeff_loader_pkg.sv
// lut_coeff_loader_pkg: coefficient table geometry and loader state encoding
package lut_coeff_loader_pkg;
  localparam int LUT_BINS = 256;
  localparam int LUT_SEGMENTS = 14;
  localparam int LUT_DEPTH = LUT_BINS * LUT_SEGMENTS;
  localparam int LUT_ADDR_WIDTH = 12;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
endpackage

// File: rtl/lut_coeff_loader_read_tag_pipe.sv
// lut_read_tag_pipe: LATENCY-deep shift register of read tags (d in, q out after LATENCY clocks)
module lut_read_tag_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [LATENCY];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < LATENCY; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[LATENCY-1];
endmodule

// File: rtl/lut_coeff_loader.sv
// lut_coeff_loader: loads/verifies a coefficient memory from a valid/ready stream (start,in_*), then muxes the port to the pipeline (pipe_*); lut_* drive the memory; busy/table_valid/error/checksum report status
module lut_coeff_loader import lut_coeff_loader_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = LUT_DEPTH,
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] pipe_address,
  input  logic                  pipe_rden,
  output logic [DATA_WIDTH-1:0] pipe_q,
  output logic [ADDR_WIDTH-1:0] lut_address,
  output logic [DATA_WIDTH-1:0] lut_data,
  output logic                  lut_wren,
  output logic                  lut_rden,
  input  logic [DATA_WIDTH-1:0] lut_q,
  output logic                  busy,
  output logic                  table_valid,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, ld_address;
  logic [DATA_WIDTH-1:0] wsum, rsum, rsum_nx, ld_data;
  logic ld_wren, ld_rden, ld_last, rd_done, err;
  logic tag_valid, tag_last, accept, issue, finish, idle_or_done;
  assign idle_or_done = state == IDLE || state == DONE;
  assign accept = state == LOAD && in_valid;
  assign issue = state == VERIFY && !rd_done;
  assign finish = state == VERIFY && tag_valid && tag_last;
  assign rsum_nx = tag_valid ? rsum + lut_q : rsum;
  lut_read_tag_pipe #(.LATENCY(READ_LATENCY), .WIDTH(2)) u_tag (
    .clk(clk),
    .rst(rst),
    .d({ld_rden, ld_last}),
    .q({tag_valid, tag_last})
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? LOAD : state;
      LOAD: state_nx = (in_valid && wr_ptr == LAST) ? VERIFY : LOAD;
      VERIFY: state_nx = finish ? (rsum_nx == wsum ? DONE : IDLE) : VERIFY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      wsum <= '0;
      rsum <= '0;
      err <= 1'b0;
      rd_done <= 1'b0;
      ld_address <= '0;
      ld_data <= '0;
      ld_wren <= 1'b0;
      ld_rden <= 1'b0;
      ld_last <= 1'b0;
    end else begin
      state <= state_nx;
      ld_wren <= accept;
      ld_rden <= issue;
      ld_last <= issue && rd_ptr == LAST;
      if (accept) begin
        ld_address <= wr_ptr;
        ld_data <= in_data;
        wsum <= wsum + in_data;
        if (wr_ptr != LAST) wr_ptr <= wr_ptr + 1'b1;
      end else if (issue) begin
        ld_address <= rd_ptr;
        if (rd_ptr == LAST) rd_done <= 1'b1;
        else rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == VERIFY) rsum <= rsum_nx;
      if (finish && rsum_nx != wsum) err <= 1'b1;
      if (start && idle_or_done) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        wsum <= '0;
        rsum <= '0;
        err <= 1'b0;
        rd_done <= 1'b0;
      end
    end
  end
  assign busy = !idle_or_done;
  assign in_ready = state == LOAD;
  assign table_valid = state == DONE;
  assign error = err;
  assign checksum = wsum;
  assign lut_address = busy ? ld_address : pipe_address;
  assign lut_rden = busy ? ld_rden : pipe_rden;
  assign lut_wren = busy && ld_wren;
  assign lut_data = ld_data;
  assign pipe_q = lut_q;
endmodule

// File: tb/tb_lut_coeff_loader.sv
// tb_lut_coeff_loader: directed self-checking bench with a behavioural single-port memory
module tb_lut_coeff_loader;
  localparam int DW = 32;
  localparam int DEPTH = 3584;
  localparam int AW = 12;
  localparam int RL = 1;
  logic clk, rst, start, in_valid, in_ready, pipe_rden, lut_wren, lut_rden;
  logic busy, table_valid, error;
  logic [DW-1:0] in_data, pipe_q, lut_data, lut_q, checksum, q_reg;
  logic [AW-1:0] pipe_address, lut_address;
  logic [DW-1:0] mem [DEPTH];
  bit corrupt;
  int wr_cnt, wr_bad, pass_cnt, total;
  lut_coeff_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pipe_address(pipe_address), .pipe_rden(pipe_rden),
    .pipe_q(pipe_q), .lut_address(lut_address), .lut_data(lut_data),
    .lut_wren(lut_wren), .lut_rden(lut_rden), .lut_q(lut_q), .busy(busy),
    .table_valid(table_valid), .error(error), .checksum(checksum)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  assign lut_q = q_reg;
  always @(posedge clk) begin
    if (lut_wren) mem[lut_address] <= lut_data;
    if (lut_rden) q_reg <= mem[lut_address] ^ {31'b0, corrupt && lut_address == AW'(100)};
    if (start && !busy) begin
      wr_cnt <= 0;
      wr_bad <= 0;
    end else if (lut_wren) begin
      wr_bad <= wr_bad + ((lut_address != AW'(wr_cnt)) ? 1 : 0);
      wr_cnt <= wr_cnt + 1;
    end
  end
  task automatic load(input logic [DW-1:0] off, input bit stall, input bit pipe_drive,
                      input bit start_valid, input bit verify_start, input bit exp_ok);
    int i, cyc, n, rd_in_load;
    logic [DW-1:0] exp;
    exp = 0;
    for (int k = 0; k < DEPTH; k++) exp += 32'(k) + off;
    @(negedge clk);
    start = 1; in_valid = start_valid; in_data = 32'hBAD0_0000;
    @(negedge clk);
    start = 0;
    #1;
    total++;
    if ({error, busy, in_ready, table_valid} !== 4'b0110) $display("FAIL load_start: err/busy/rdy/tv got %b expected 0110", {error, busy, in_ready, table_valid});
    else pass_cnt++;
    i = 0; cyc = 0; rd_in_load = 0;
    while (i < DEPTH && cyc < 3 * DEPTH) begin
      in_valid = !stall || (cyc % 2 == 0);
      in_data = in_valid ? 32'(i) + off : 32'hDEAD_BEEF;
      pipe_rden = pipe_drive;
      pipe_address = pipe_drive ? AW'(255) : '0;
      #1;
      if (lut_rden) rd_in_load++;
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 0; pipe_rden = 0; pipe_address = '0;
    total++;
    if (i != DEPTH) $display("FAIL load_accept: accepted %0d words expected %0d (cycle budget)", i, DEPTH);
    else pass_cnt++;
    n = 0;
    while (busy && n < DEPTH + 50) begin
      start = verify_start && n == 3;
      @(negedge clk);
      start = 0;
      n++;
      if (verify_start && n == 4) begin
        total++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL verify_start_ignored: busy/rdy got %b expected 10", {busy, in_ready});
        else pass_cnt++;
      end
    end
    total++;
    if (n != DEPTH + RL + 1) $display("FAIL verify_cycles: got %0d expected %0d", n, DEPTH + RL + 1);
    else pass_cnt++;
    total++;
    if (checksum !== exp) $display("FAIL checksum: got %h expected %h", checksum, exp);
    else pass_cnt++;
    total++;
    if (wr_cnt != DEPTH || wr_bad != 0) $display("FAIL wren_seq: writes %0d bad_addr %0d expected %0d and 0", wr_cnt, wr_bad, DEPTH);
    else pass_cnt++;
    total++;
    if ({table_valid, error} !== {exp_ok, !exp_ok}) $display("FAIL result: tv/err got %b expected %b", {table_valid, error}, {exp_ok, !exp_ok});
    else pass_cnt++;
    if (pipe_drive) begin
      total++;
      if (rd_in_load != 0) $display("FAIL pipe_in_load: rden seen %0d cycles expected 0", rd_in_load);
      else pass_cnt++;
    end
  endtask
  task automatic test_mem(input logic [DW-1:0] off);
    int bad;
    bad = 0;
    for (int j = 0; j < DEPTH; j++) if (mem[j] !== 32'(j) + off) bad++;
    total++;
    if (bad != 0) $display("FAIL mem_contents: %0d wrong words expected 0", bad);
    else pass_cnt++;
  endtask
  task automatic test_reset;
    rst = 1; start = 0; in_valid = 0; in_data = 0; pipe_rden = 0; pipe_address = '0; corrupt = 0;
    #12;
    total++;
    if ({in_ready, lut_wren, lut_rden, busy, table_valid, error} !== 6'b0) $display("FAIL reset_flags: got %b expected 000000", {in_ready, lut_wren, lut_rden, busy, table_valid, error});
    else pass_cnt++;
    total++;
    if (lut_address !== '0 || lut_data !== '0 || checksum !== '0) $display("FAIL reset_buses: addr %h data %h sum %h expected 0", lut_address, lut_data, checksum);
    else pass_cnt++;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_basic;
    load(32'd0, 0, 0, 0, 0, 1);
    total++;
    if (checksum !== 32'h0061_F900) $display("FAIL checksum_const: got %h expected 0061f900", checksum);
    else pass_cnt++;
    test_mem(32'd0);
  endtask
  task automatic test_pipe;
    @(negedge clk);
    pipe_address = AW'(255); pipe_rden = 1;
    #1;
    total++;
    if (lut_rden !== 1'b1 || lut_address !== AW'(255) || lut_wren !== 1'b0) $display("FAIL pipe_mux: rden %b addr %h wren %b expected 1 0ff 0", lut_rden, lut_address, lut_wren);
    else pass_cnt++;
    @(negedge clk);
    pipe_rden = 0; pipe_address = '0;
    total++;
    if (pipe_q !== 32'd255) $display("FAIL pipe_q: got %h expected 000000ff", pipe_q);
    else pass_cnt++;
  endtask
  task automatic test_corrupt;
    corrupt = 1;
    load(32'd5, 0, 0, 0, 0, 0);
    corrupt = 0;
    total++;
    if (busy !== 1'b0) $display("FAIL corrupt_idle: busy got %b expected 0", busy);
    else pass_cnt++;
  endtask
  task automatic test_stall;
    load(32'd0, 1, 1, 0, 0, 1);
    test_mem(32'd0);
  endtask
  task automatic test_reset_mid;
    int i;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    i = 0;
    while (i < 2000) begin
      in_valid = 1; in_data = 32'(i) + 32'd7;
      @(negedge clk);
      i++;
    end
    in_valid = 0;
    rst = 1;
    #1;
    total++;
    if ({in_ready, lut_wren, lut_rden, busy, table_valid, error} !== 6'b0) $display("FAIL midrst_flags: got %b expected 000000", {in_ready, lut_wren, lut_rden, busy, table_valid, error});
    else pass_cnt++;
    total++;
    if (lut_address !== '0 || lut_data !== '0 || checksum !== '0) $display("FAIL midrst_buses: addr %h data %h sum %h expected 0", lut_address, lut_data, checksum);
    else pass_cnt++;
    @(negedge clk);
    rst = 0;
    load(32'd0, 0, 0, 1, 1, 1);
    test_mem(32'd0);
  endtask
  initial begin
    pass_cnt = 0; total = 0;
    test_reset;
    test_basic;
    test_pipe;
    test_corrupt;
    test_stall;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
